// File: rtl/lsu_pkg.sv
// lsu_pkg: widths, issue-queue entry type and wakeup tag match shared across the LSU
// Contents: PREG_W/ROB_W/LSQ_W/WB_PORTS widths, iq_entry_t, wb_hit() tag compare
package lsu_pkg;
  localparam int PREG_W = 7;
  localparam int ROB_W = 3;
  localparam int LSQ_W = 2;
  localparam int WB_PORTS = 2;
  typedef struct packed {
    logic valid;
    logic is_store;
    logic [PREG_W-1:0] rs1_preg;
    logic rs1_rdy;
    logic [PREG_W-1:0] rs2_preg;
    logic rs2_rdy;
    logic [31:0] imm;
    logic [ROB_W-1:0] rob_idx;
    logic [LSQ_W-1:0] lsq_idx;
  } iq_entry_t;
  function automatic logic wb_hit(input logic [PREG_W-1:0] tag, input logic [WB_PORTS-1:0] v,
                                  input logic [WB_PORTS*PREG_W-1:0] p);
    wb_hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++)
      if (v[k] && p[k*PREG_W +: PREG_W] == tag) wb_hit = 1'b1;
  endfunction
endpackage

// File: rtl/lsu_iq_age_matrix.sv
// lsu_iq_age_matrix: relative-age tracking and oldest-request pick for the issue queue
// Ports: clk/rst (async active-low), alloc (one-hot entry written this cycle),
//        live (entries still valid after this cycle, excluding alloc), free (entries leaving),
//        req (ready entries), blk (entries that block younger ones),
//        grant (one-hot oldest req), older_blk (entry has an older blk entry)
module lsu_iq_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] live,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  input  logic [DEPTH-1:0] blk,
  output logic [DEPTH-1:0] grant,
  output logic [DEPTH-1:0] older_blk
);
  // older_q[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  always_comb begin
    grant = '0;
    older_blk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i] & ~|(older_q[i] & req);
      older_blk[i] = |(older_q[i] & blk);
    end
  end
  // a new entry is younger than every survivor; a leaving entry stops being older than anyone
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++)
      older_d[i] = alloc[i] ? live : (older_q[i] & ~free);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) older_q <= '0;
    else older_q <= older_d;
endmodule

// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: memory-op reservation station; wakes ops on writeback, issues oldest ready
// Ports: clk, rst (async active-low); dispatch dc_* (valid/ready handshake);
//        wakeup wb_valid/wb_preg; issue iss_* (valid/ready handshake);
//        mispredict + flush_mask kill by ROB slot; occupancy = valid entry count
// Option: LSU_IQ_STORE_ORDER_EN keeps stores in program order (loads unaffected)
module lsu_issue_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dc_valid,
  output logic                       dc_ready,
  input  logic                       dc_is_store,
  input  logic [PREG_W-1:0]          dc_rs1_preg,
  input  logic                       dc_rs1_rdy,
  input  logic [PREG_W-1:0]          dc_rs2_preg,
  input  logic                       dc_rs2_rdy,
  input  logic [31:0]                dc_imm,
  input  logic [ROB_W-1:0]           dc_rob_idx,
  input  logic [LSQ_W-1:0]           dc_lsq_idx,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_preg,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic                       iss_is_store,
  output logic [PREG_W-1:0]          iss_rs1_preg,
  output logic [PREG_W-1:0]          iss_rs2_preg,
  output logic [31:0]                iss_imm,
  output logic [ROB_W-1:0]           iss_rob_idx,
  output logic [LSQ_W-1:0]           iss_lsq_idx,
  input  logic                       mispredict,
  input  logic [2**ROB_W-1:0]        flush_mask,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  iq_entry_t [DEPTH-1:0] ent_q, ent_d;
  iq_entry_t sel, new_ent;
  logic [OCC_W-1:0] occ_q, occ_d, free_cnt;
  logic [DEPTH-1:0] valid, flushed, blk, ready, grant, older_blk, free, live, alloc;
  logic fire, disp;
  always_comb begin
    valid = '0;
    flushed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ent_q[i].valid;
      flushed[i] = mispredict & ent_q[i].valid & flush_mask[ent_q[i].rob_idx];
    end
  end
  always_comb begin
    blk = '0;
`ifdef LSU_IQ_STORE_ORDER_EN
    for (int i = 0; i < DEPTH; i++) blk[i] = ent_q[i].valid & ent_q[i].is_store;
`endif
  end
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = valid[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy & ~(ent_q[i].is_store & older_blk[i]);
  end
  lsu_iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk(clk),
    .rst(rst),
    .alloc(alloc),
    .live(live),
    .free(free),
    .req(ready),
    .blk(blk),
    .grant(grant),
    .older_blk(older_blk)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) if (grant[i]) sel = ent_q[i];
    iss_valid = sel.valid & sel.rs1_rdy & sel.rs2_rdy & ~mispredict;
    fire = iss_valid & iss_ready;
    free = flushed | (fire ? grant : '0);
    live = valid & ~free;
    disp = dc_valid & dc_ready & ~mispredict;
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) begin
        alloc = '0;
        alloc[i] = disp;
      end
    // dispatching op sees this cycle's wakeups; loads have no second operand
    new_ent = '{valid: 1'b1, is_store: dc_is_store,
                rs1_preg: dc_rs1_preg, rs1_rdy: dc_rs1_rdy | wb_hit(dc_rs1_preg, wb_valid, wb_preg),
                rs2_preg: dc_rs2_preg,
                rs2_rdy: ~dc_is_store | dc_rs2_rdy | wb_hit(dc_rs2_preg, wb_valid, wb_preg),
                imm: dc_imm, rob_idx: dc_rob_idx, lsq_idx: dc_lsq_idx};
    ent_d = ent_q;
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].rs1_rdy = ent_q[i].rs1_rdy | wb_hit(ent_q[i].rs1_preg, wb_valid, wb_preg);
      ent_d[i].rs2_rdy = ent_q[i].rs2_rdy | wb_hit(ent_q[i].rs2_preg, wb_valid, wb_preg);
      if (free[i]) ent_d[i].valid = 1'b0;
      if (alloc[i]) ent_d[i] = new_ent;
      free_cnt = free_cnt + OCC_W'(free[i]);
    end
    occ_d = occ_q + OCC_W'(disp) - free_cnt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ent_q <= '0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
    end
  assign dc_ready = occ_q < OCC_W'(DEPTH);
  assign occupancy = occ_q;
  assign iss_is_store = sel.is_store;
  assign iss_rs1_preg = sel.rs1_preg;
  assign iss_rs2_preg = sel.rs2_preg;
  assign iss_imm = sel.imm;
  assign iss_rob_idx = sel.rob_idx;
  assign iss_lsq_idx = sel.lsq_idx;
endmodule

// File: tb/tb_lsu_issue_queue.sv
// tb_lsu_issue_queue: directed self-checking bench for lsu_issue_queue
module tb_lsu_issue_queue;
  logic clk = 1'b0, rst = 1'b0;
  logic dc_valid, dc_ready, dc_is_store, dc_rs1_rdy, dc_rs2_rdy;
  logic [6:0] dc_rs1_preg, dc_rs2_preg;
  logic [31:0] dc_imm;
  logic [2:0] dc_rob_idx;
  logic [1:0] dc_lsq_idx;
  logic [1:0] wb_valid;
  logic [13:0] wb_preg;
  logic iss_valid, iss_ready, iss_is_store;
  logic [6:0] iss_rs1_preg, iss_rs2_preg;
  logic [31:0] iss_imm;
  logic [2:0] iss_rob_idx;
  logic [1:0] iss_lsq_idx;
  logic mispredict;
  logic [7:0] flush_mask;
  logic [2:0] occupancy;
  int checks = 0, errors = 0;

  lsu_issue_queue dut (
    .clk(clk), .rst(rst),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_is_store(dc_is_store),
    .dc_rs1_preg(dc_rs1_preg), .dc_rs1_rdy(dc_rs1_rdy),
    .dc_rs2_preg(dc_rs2_preg), .dc_rs2_rdy(dc_rs2_rdy),
    .dc_imm(dc_imm), .dc_rob_idx(dc_rob_idx), .dc_lsq_idx(dc_lsq_idx),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_store(iss_is_store),
    .iss_rs1_preg(iss_rs1_preg), .iss_rs2_preg(iss_rs2_preg), .iss_imm(iss_imm),
    .iss_rob_idx(iss_rob_idx), .iss_lsq_idx(iss_lsq_idx),
    .mispredict(mispredict), .flush_mask(flush_mask), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dc_valid = 1'b0; dc_is_store = 1'b0; dc_rs1_preg = '0; dc_rs1_rdy = 1'b0;
    dc_rs2_preg = '0; dc_rs2_rdy = 1'b0; dc_imm = '0; dc_rob_idx = '0; dc_lsq_idx = '0;
    wb_valid = '0; wb_preg = '0; mispredict = 1'b0; flush_mask = '0;
  endtask

  task automatic set_op(input logic st, input logic [6:0] r1, input logic r1r, input logic [6:0] r2,
                        input logic r2r, input logic [31:0] imm, input logic [2:0] rob, input logic [1:0] lsq);
    dc_valid = 1'b1; dc_is_store = st; dc_rs1_preg = r1; dc_rs1_rdy = r1r;
    dc_rs2_preg = r2; dc_rs2_rdy = r2r; dc_imm = imm; dc_rob_idx = rob; dc_lsq_idx = lsq;
  endtask

  task automatic test_reset;
    idle();
    iss_ready = 1'b0;
    #3;
    checks++; if (dc_ready !== 1'b1) begin errors++; $display("FAIL reset_dc_ready got %0b exp 1", dc_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %0b exp 0", iss_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if ({iss_rs1_preg, iss_imm, iss_rob_idx} !== 42'd0) begin errors++; $display("FAIL reset_iss_data got %0h exp 0", {iss_rs1_preg, iss_imm, iss_rob_idx}); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_load_issue;
    iss_ready = 1'b1;
    set_op(1'b0, 7'd5, 1'b1, 7'd0, 1'b0, 32'h10, 3'd2, 2'd1);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL load_empty_valid got %0b exp 0", iss_valid); end
    step();
    dc_valid = 1'b0;
    #1;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %0b exp 1", iss_valid); end
    checks++; if ({iss_is_store, iss_rs1_preg, iss_imm, iss_rob_idx, iss_lsq_idx} !== {1'b0, 7'd5, 32'h10, 3'd2, 2'd1})
      begin errors++; $display("FAIL load_fields got st%0b rs1 %0d imm %0h rob %0d lsq %0d exp st0 rs1 5 imm 10 rob 2 lsq 1", iss_is_store, iss_rs1_preg, iss_imm, iss_rob_idx, iss_lsq_idx); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL load_occ got %0d exp 1", occupancy); end
    step();
    checks++; if ({iss_valid, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL load_freed got valid %0b occ %0d exp 0 0", iss_valid, occupancy); end
  endtask

  task automatic test_wakeup;
    iss_ready = 1'b1;
    set_op(1'b1, 7'd3, 1'b1, 7'd9, 1'b0, 32'h20, 3'd3, 2'd2);
    step();
    dc_valid = 1'b0;
    #1;
    checks++; if ({iss_valid, occupancy} !== {1'b0, 3'd1}) begin errors++; $display("FAIL wake_wait got valid %0b occ %0d exp 0 1", iss_valid, occupancy); end
    step();
    wb_valid = 2'b01; wb_preg = {7'd0, 7'd9};
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got %0b exp 0", iss_valid); end
    step();
    wb_valid = '0;
    #1;
    checks++; if ({iss_valid, iss_is_store, iss_rs1_preg, iss_rs2_preg} !== {1'b1, 1'b1, 7'd3, 7'd9})
      begin errors++; $display("FAIL wake_issue got valid %0b st %0b rs1 %0d rs2 %0d exp 1 1 3 9", iss_valid, iss_is_store, iss_rs1_preg, iss_rs2_preg); end
    step();
    checks++; if ({iss_valid, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL wake_freed got valid %0b occ %0d exp 0 0", iss_valid, occupancy); end
  endtask

  task automatic test_bypass;
    iss_ready = 1'b1;
    set_op(1'b0, 7'd20, 1'b0, 7'd0, 1'b0, 32'h30, 3'd4, 2'd3);
    wb_valid = 2'b10; wb_preg = {7'd20, 7'd0};
    step();
    idle();
    #1;
    checks++; if ({iss_valid, iss_rs1_preg, iss_lsq_idx} !== {1'b1, 7'd20, 2'd3}) begin errors++; $display("FAIL bypass got valid %0b rs1 %0d lsq %0d exp 1 20 3", iss_valid, iss_rs1_preg, iss_lsq_idx); end
    step();
  endtask

  task automatic test_fill;
    logic [2:0] exp_rob [4];
    exp_rob = '{3'd1, 3'd2, 3'd3, 3'd4};
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(1'b0, 7'(10 + i), 1'b1, 7'd0, 1'b0, 32'(i), 3'(i), 2'(i));
      step();
    end
    set_op(1'b0, 7'd40, 1'b1, 7'd0, 1'b0, 32'h44, 3'd4, 2'd0);
    #1;
    checks++; if ({occupancy, dc_ready, iss_rob_idx} !== {3'd4, 1'b0, 3'd0}) begin errors++; $display("FAIL fill_full got occ %0d rdy %0b rob %0d exp 4 0 0", occupancy, dc_ready, iss_rob_idx); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    #1;
    checks++; if ({occupancy, dc_ready, iss_rob_idx} !== {3'd3, 1'b1, 3'd1}) begin errors++; $display("FAIL fill_refused got occ %0d rdy %0b rob %0d exp 3 1 1", occupancy, dc_ready, iss_rob_idx); end
    step();
    dc_valid = 1'b0;
    #1;
    checks++; if ({occupancy, dc_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL fill_fifth got occ %0d rdy %0b exp 4 0", occupancy, dc_ready); end
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({iss_valid, iss_rob_idx} !== {1'b1, exp_rob[k]}) begin errors++; $display("FAIL fill_drain%0d got valid %0b rob %0d exp 1 %0d", k, iss_valid, iss_rob_idx, exp_rob[k]); end
      step();
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", occupancy); end
    iss_ready = 1'b0;
  endtask

  task automatic test_flush;
    iss_ready = 1'b0;
    set_op(1'b0, 7'd21, 1'b1, 7'd0, 1'b0, 32'h0, 3'd1, 2'd0); step();
    set_op(1'b0, 7'd50, 1'b0, 7'd0, 1'b0, 32'h0, 3'd3, 2'd1); step();
    set_op(1'b1, 7'd51, 1'b0, 7'd52, 1'b0, 32'h0, 3'd5, 2'd2); step();
    dc_valid = 1'b0;
    #1;
    checks++; if ({iss_valid, iss_rob_idx, occupancy} !== {1'b1, 3'd1, 3'd3}) begin errors++; $display("FAIL flush_pre got valid %0b rob %0d occ %0d exp 1 1 3", iss_valid, iss_rob_idx, occupancy); end
    mispredict = 1'b1; flush_mask = 8'b0010_1000;
    set_op(1'b0, 7'd22, 1'b1, 7'd0, 1'b0, 32'h0, 3'd6, 2'd3);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_valid got %0b exp 0", iss_valid); end
    step();
    idle();
    #1;
    checks++; if ({occupancy, iss_valid, iss_rob_idx} !== {3'd1, 1'b1, 3'd1}) begin errors++; $display("FAIL flush_post got occ %0d valid %0b rob %0d exp 1 1 1", occupancy, iss_valid, iss_rob_idx); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_drain got %0d exp 0", occupancy); end
  endtask

  task automatic test_back_to_back;
    iss_ready = 1'b0;
    set_op(1'b0, 7'd7, 1'b1, 7'd0, 1'b0, 32'hA, 3'd0, 2'd0); step();
    set_op(1'b1, 7'd8, 1'b1, 7'd9, 1'b1, 32'hB, 3'd1, 2'd2); step();
    dc_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({iss_valid, iss_rob_idx, iss_imm} !== {1'b1, 3'd0, 32'hA}) begin errors++; $display("FAIL b2b_hold%0d got valid %0b rob %0d imm %0h exp 1 0 a", c, iss_valid, iss_rob_idx, iss_imm); end
      step();
    end
    iss_ready = 1'b1;
    #1;
    checks++; if ({iss_valid, iss_rob_idx} !== {1'b1, 3'd0}) begin errors++; $display("FAIL b2b_first got valid %0b rob %0d exp 1 0", iss_valid, iss_rob_idx); end
    step();
    checks++; if ({iss_valid, iss_rob_idx, iss_imm, iss_is_store, iss_lsq_idx} !== {1'b1, 3'd1, 32'hB, 1'b1, 2'd2})
      begin errors++; $display("FAIL b2b_second got valid %0b rob %0d imm %0h st %0b lsq %0d exp 1 1 b 1 2", iss_valid, iss_rob_idx, iss_imm, iss_is_store, iss_lsq_idx); end
    step();
    checks++; if ({iss_valid, occupancy} !== {1'b0, 3'd0}) begin errors++; $display("FAIL b2b_empty got valid %0b occ %0d exp 0 0", iss_valid, occupancy); end
    iss_ready = 1'b0;
  endtask

  task automatic test_store_order;
    logic [2:0] exp_first;
`ifdef LSU_IQ_STORE_ORDER_EN
    exp_first = 3'd2;
`else
    exp_first = 3'd1;
`endif
    iss_ready = 1'b0;
    set_op(1'b1, 7'd30, 1'b1, 7'd60, 1'b0, 32'h1, 3'd0, 2'd0); step();
    set_op(1'b1, 7'd31, 1'b1, 7'd32, 1'b1, 32'h2, 3'd1, 2'd1); step();
    set_op(1'b0, 7'd33, 1'b1, 7'd0, 1'b0, 32'h3, 3'd2, 2'd2); step();
    dc_valid = 1'b0;
    #1;
    checks++; if ({iss_valid, iss_rob_idx} !== {1'b1, exp_first}) begin errors++; $display("FAIL order_pick got valid %0b rob %0d exp 1 %0d", iss_valid, iss_rob_idx, exp_first); end
    wb_valid = 2'b01; wb_preg = {7'd0, 7'd60};
    step();
    wb_valid = '0;
    iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({iss_valid, iss_rob_idx} !== {1'b1, 3'(k)}) begin errors++; $display("FAIL order_drain%0d got valid %0b rob %0d exp 1 %0d", k, iss_valid, iss_rob_idx, k); end
      step();
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL order_empty got %0d exp 0", occupancy); end
    iss_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    iss_ready = 1'b0;
    set_op(1'b0, 7'd11, 1'b1, 7'd0, 1'b0, 32'h55, 3'd5, 2'd1); step();
    set_op(1'b0, 7'd12, 1'b0, 7'd0, 1'b0, 32'h66, 3'd6, 2'd2); step();
    dc_valid = 1'b0;
    #1;
    checks++; if ({occupancy, iss_valid} !== {3'd2, 1'b1}) begin errors++; $display("FAIL arst_pre got occ %0d valid %0b exp 2 1", occupancy, iss_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({occupancy, iss_valid, dc_ready, iss_imm} !== {3'd0, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL arst_clear got occ %0d valid %0b rdy %0b imm %0h exp 0 0 1 0", occupancy, iss_valid, dc_ready, iss_imm); end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if ({occupancy, iss_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL arst_post got occ %0d valid %0b exp 0 0", occupancy, iss_valid); end
  endtask

  initial begin
    test_reset();
    test_load_issue();
    test_wakeup();
    test_bypass();
    test_fill();
    test_flush();
    test_back_to_back();
    test_store_order();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
